// File: rtl/uart_cmd_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_cmd_controller_if : UART receive/transmit handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface uart_cmd_controller_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  // master: the command controller; slave: the UART receiver/transmitter pair
  modport master (input rx_data, rx_valid, tx_busy, output tx_data, tx_start);
  modport slave  (output rx_data, rx_valid, tx_busy, input tx_data, tx_start);
endinterface
`default_nettype wire

// File: rtl/uart_cmd_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_cmd_controller : single-byte command interpreter (R/W/E/C) over UART
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_cmd_controller #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  wire logic             clk,
  input  wire logic             rst,
  uart_cmd_controller_if.master bus,
  input  wire logic [7:0]       switches,
  output logic      [7:0]       leds,
  output logic                  overrun,
  output logic      [7:0]       err_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    SEND      = 3'd2,
    TX_WAIT   = 3'd3,
    TX_DONE   = 3'd4
  } state_t;

  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  c_CMD_READ     = 8'h52;
  localparam logic [7:0]  c_CMD_WRITE    = 8'h57;
  localparam logic [7:0]  c_CMD_ERR      = 8'h45;
  localparam logic [7:0]  c_CMD_CLEAR    = 8'h43;
  localparam logic [7:0]  c_RSP_OK       = 8'h4B;
  localparam logic [7:0]  c_RSP_BAD      = 8'h3F;
  localparam logic [7:0]  c_RSP_TIMEOUT  = 8'h54;

  state_t      r_state;
  logic [7:0]  r_leds;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;
  logic        r_overrun;
  logic [7:0]  r_err_cnt;
  logic [15:0] r_timeout;

  logic        w_drop;
  logic [7:0]  w_err_next;

  // A byte arriving while a response is still in flight cannot be serviced.
  assign w_drop     = bus.rx_valid &&
                      ((r_state == SEND) || (r_state == TX_WAIT) || (r_state == TX_DONE));
  assign w_err_next = (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_leds     <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_overrun  <= 1'b0;
      r_err_cnt  <= 8'h00;
      r_timeout  <= 16'h0000;
    end else begin
      r_tx_start <= 1'b0;

      if (w_drop) begin
        r_overrun <= 1'b1;
        r_err_cnt <= w_err_next;
      end

      case (r_state)
        IDLE: begin
          if (bus.rx_valid) begin
            case (bus.rx_data)
              c_CMD_READ: begin
                r_tx_data <= switches;
                r_state   <= SEND;
              end
              c_CMD_WRITE: begin
                r_timeout <= 16'h0000;
                r_state   <= WAIT_DATA;
              end
              c_CMD_ERR: begin
                r_tx_data <= r_err_cnt;
                r_state   <= SEND;
              end
              c_CMD_CLEAR: begin
                r_err_cnt <= 8'h00;
                r_overrun <= 1'b0;
                r_tx_data <= c_RSP_OK;
                r_state   <= SEND;
              end
              default: begin
                r_tx_data <= c_RSP_BAD;
                r_err_cnt <= w_err_next;
                r_state   <= SEND;
              end
            endcase
          end
        end

        WAIT_DATA: begin
          // The data byte wins over a timeout landing on the same cycle.
          if (bus.rx_valid) begin
            r_leds    <= bus.rx_data;
            r_tx_data <= c_RSP_OK;
            r_state   <= SEND;
          end else if (r_timeout == c_TIMEOUT_LAST) begin
            r_tx_data <= c_RSP_TIMEOUT;
            r_err_cnt <= w_err_next;
            r_state   <= SEND;
          end else begin
            r_timeout <= r_timeout + 16'd1;
          end
        end

        SEND: begin
          if (!bus.tx_busy) begin
            r_tx_start <= 1'b1;
            r_state    <= TX_WAIT;
          end
        end

        TX_WAIT: begin
          if (bus.tx_busy) begin
            r_state <= TX_DONE;
          end
        end

        TX_DONE: begin
          if (!bus.tx_busy) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign leds         = r_leds;
  assign overrun      = r_overrun;
  assign err_cnt      = r_err_cnt;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = r_tx_start;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_cmd_controller : directed bench with a transaction-level reference
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_cmd_controller;

  localparam int TO      = 4096;
  localparam int TX_BITS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] switches = 8'h00;
  logic [7:0] leds;
  logic       overrun;
  logic [7:0] err_cnt;
  logic       hold_busy = 1'b0;
  logic       x_busy;
  int         x_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;

  uart_cmd_controller_if bus();

  uart_cmd_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .switches (switches),
    .leds     (leds),
    .overrun  (overrun),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Transmitter stand-in: busy from the cycle after tx_start for TX_BITS+1 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      x_busy <= 1'b0;
      x_cnt  <= 0;
    end else if (bus.tx_start) begin
      x_busy <= 1'b1;
      x_cnt  <= TX_BITS;
    end else if (x_busy) begin
      if (x_cnt == 0) x_busy <= 1'b0;
      else            x_cnt  <= x_cnt - 1;
    end
  end

  assign bus.tx_busy = x_busy | hold_busy;

  // Reference: what the controller owes the host, tracked per transaction.
  bit         m_await, m_pend, m_fly, m_seen, m_txs, m_ovr;
  int         m_wait;
  logic [7:0] m_leds, m_err, m_txd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_await = 0; m_pend = 0; m_fly = 0; m_seen = 0; m_txs = 0; m_ovr = 0;
    m_wait = 0; m_leds = 8'h00; m_err = 8'h00; m_txd = 8'h00;
  endtask

  task automatic bump();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  task automatic respond(input logic [7:0] b);
    m_txd = b; m_pend = 1; m_await = 0;
  endtask

  task automatic model_step();
    bit         v = bus.rx_valid;
    logic [7:0] d = bus.rx_data;
    bit         b = bus.tx_busy;
    m_txs = 0;
    if (m_pend || m_fly) begin
      if (v) begin m_ovr = 1; bump(); end
      if (m_pend) begin
        if (!b) begin m_pend = 0; m_fly = 1; m_seen = 0; m_txs = 1; end
      end else if (!m_seen) begin
        m_seen = b;
      end else if (!b) begin
        m_fly = 0;
      end
    end else if (m_await) begin
      if (v) begin m_leds = d; respond(8'h4B); end
      else if (m_wait == TO - 1) begin respond(8'h54); bump(); end
      else m_wait++;
    end else if (v) begin
      case (d)
        8'h52: respond(switches);
        8'h57: begin m_await = 1; m_wait = 0; end
        8'h45: respond(m_err);
        8'h43: begin m_err = 8'h00; m_ovr = 0; respond(8'h4B); end
        default: begin respond(8'h3F); bump(); end
      endcase
    end
  endtask

  task automatic compare();
    if (rst) begin
      chk("rst_leds", leds, 0);
      chk("rst_tx_data", bus.tx_data, 0);
      chk("rst_tx_start", bus.tx_start, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_err_cnt", err_cnt, 0);
    end else begin
      if (bus.tx_start) n_starts++;
      chk("leds", leds, m_leds);
      chk("err_cnt", err_cnt, m_err);
      chk("overrun", overrun, m_ovr);
      chk("tx_start", bus.tx_start, m_txs);
      chk("tx_data", bus.tx_data, m_txd);
    end
  endtask

  // All stimulus advances through tick(): model at the edge, compare at the negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic wait_quiet(input int limit);
    int  n = 0;
    bit  active = m_pend || m_fly || m_await;
    while (active && n < limit) begin
      tick();
      n++;
      active = m_pend || m_fly || m_await;
    end
    chk("quiet_bound", active, 0);
    tick();
  endtask

  initial begin
    model_reset();
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) tick();
    chk("reset_leds", leds, 8'h00);
    chk("reset_err", err_cnt, 8'h00);
    rst = 1'b0;
    repeat (2) tick();

    // Write: leds take the data byte on its edge, one 'K' response.
    n_starts = 0;
    send(8'h57);
    send(8'hA5);
    chk("w_leds", leds, 8'hA5);
    chk("w_model_leds", m_leds, 8'hA5);
    wait_quiet(100);
    chk("w_starts", n_starts, 1);
    chk("w_txd", bus.tx_data, 8'h4B);

    // Read: tx_start two edges after rx_valid, data held while switches move.
    switches = 8'h53;
    send(8'h52);
    chk("r_no_start_yet", bus.tx_start, 0);
    tick();
    chk("r_start", bus.tx_start, 1);
    chk("r_txd", bus.tx_data, 8'h53);
    switches = 8'hFF;
    wait_quiet(100);
    chk("r_txd_held", bus.tx_data, 8'h53);

    // Timeout after TO idle cycles in WAIT_DATA.
    send(8'h57);
    wait_quiet(TO + 100);
    chk("to_txd", bus.tx_data, 8'h54);
    chk("to_err", err_cnt, 8'h01);
    chk("to_leds", leds, 8'hA5);

    // Data arriving on the exact timeout cycle is taken as data.
    send(8'h43);
    wait_quiet(100);
    send(8'h57);
    repeat (TO - 1) tick();
    send(8'h3C);
    chk("edge_leds", leds, 8'h3C);
    chk("edge_err", err_cnt, 8'h00);
    wait_quiet(100);
    chk("edge_txd", bus.tx_data, 8'h4B);

    // Invalid byte, then a byte dropped while transmitting.
    begin
      int n = 0;
      send(8'h00);
      while (!bus.tx_busy && n < 20) begin tick(); n++; end
      chk("busy_seen", bus.tx_busy, 1);
    end
    send(8'h55);
    wait_quiet(100);
    chk("ov_txd", bus.tx_data, 8'h3F);
    chk("ov_flag", overrun, 1);
    chk("ov_err", err_cnt, 8'h02);
    send(8'h45);
    wait_quiet(100);
    chk("e_txd", bus.tx_data, 8'h02);
    send(8'h43);
    wait_quiet(100);
    chk("c_err", err_cnt, 8'h00);
    chk("c_ovr", overrun, 0);
    chk("c_txd", bus.tx_data, 8'h4B);

    // SEND holds off while the transmitter reports busy.
    n_starts  = 0;
    hold_busy = 1'b1;
    switches  = 8'h0F;
    send(8'h52);
    repeat (6) tick();
    chk("hold_no_start", n_starts, 0);
    hold_busy = 1'b0;
    wait_quiet(100);
    chk("hold_starts", n_starts, 1);
    chk("hold_txd", bus.tx_data, 8'h0F);

    // Error counter saturation, then clear.
    for (int i = 0; i < 300; i++) begin
      send(8'h60 + 8'(i % 16));
      wait_quiet(100);
    end
    chk("sat_err", err_cnt, 8'hFF);
    send(8'h43);
    wait_quiet(100);
    chk("sat_clear", err_cnt, 8'h00);

    // Asynchronous reset while waiting on the transmitter.
    switches = 8'h11;
    send(8'h52);
    tick();
    chk("pre_rst_start", bus.tx_start, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_start", bus.tx_start, 0);
    chk("arst_txd", bus.tx_data, 8'h00);
    chk("arst_leds", leds, 8'h00);
    chk("arst_err", err_cnt, 8'h00);
    chk("arst_ovr", overrun, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    switches = 8'h3C;
    send(8'h52);
    tick();
    chk("post_rst_start", bus.tx_start, 1);
    chk("post_rst_txd", bus.tx_data, 8'h3C);
    wait_quiet(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
